// File: rtl/capture_sequencer.sv
// Capture RAM sequencer: circular recording, arm-triggered freeze, then byte-wise dump of the buffer to acia_tx.
// Optional build macro CAPSEQ_HEADER_EN prepends sync bytes 0xA5, 0x5A and POST_WORDS[7:0] to every dump.
module capture_sequencer #(
    parameter int unsigned AW         = 8,
    parameter int unsigned POST_WORDS = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          word_stb,
    input  logic          arm,
    input  logic          tx_busy,
    input  logic [15:0]   ram_rdata,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_we,
    output logic [AW-1:0] ram_raddr,
    output logic          tx_start,
    output logic [7:0]    tx_dat,
    output logic          capturing,
    output logic          dumping
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [3:0] {
        S_REC,
        S_POST,
        S_DUMP_RD,
        S_DUMP_LO,
        S_DUMP_HI,
        S_WAIT_LO,
        S_WAIT_HI
`ifdef CAPSEQ_HEADER_EN
        ,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_WAIT_HDR
`endif
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   post_cnt;
    logic [AW-1:0]   rd_cnt;
    logic [15:0]     word;
    logic            rd_wait;
    logic            wait_skip;
    logic            arm_q;
    logic            arm_rise;
`ifdef CAPSEQ_HEADER_EN
    state_t          hdr_next;
`endif

    assign ram_we    = word_stb & capturing;
    assign ram_waddr = wr_ptr;
    assign arm_rise  = arm & ~arm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REC;
            wr_ptr    <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            word      <= '0;
            rd_wait   <= 1'b0;
            wait_skip <= 1'b0;
            arm_q     <= 1'b0;
            ram_raddr <= '0;
            tx_start  <= 1'b0;
            tx_dat    <= '0;
            capturing <= 1'b1;
            dumping   <= 1'b0;
`ifdef CAPSEQ_HEADER_EN
            hdr_next  <= S_HDR0;
`endif
        end else begin
            tx_start <= 1'b0;
            arm_q    <= arm;
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case (state)
                S_REC: begin
                    if (arm_rise) begin
                        post_cnt <= CW'(POST_WORDS);
                        state    <= S_POST;
                    end
                end

                S_POST: begin
                    if (ram_we) begin
                        post_cnt <= post_cnt - CW'(1);
                        // Last post-trigger write: the slot after it holds the oldest word.
                        if (post_cnt == CW'(1)) begin
                            capturing <= 1'b0;
                            dumping   <= 1'b1;
                            ram_raddr <= wr_ptr + AW'(1);
                            rd_cnt    <= '0;
                            rd_wait   <= 1'b0;
`ifdef CAPSEQ_HEADER_EN
                            state     <= S_HDR0;
`else
                            state     <= S_DUMP_RD;
`endif
                        end
                    end
                end

`ifdef CAPSEQ_HEADER_EN
                S_HDR0, S_HDR1, S_HDR2: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        wait_skip <= 1'b1;
                        state     <= S_WAIT_HDR;
                        if (state == S_HDR0) begin
                            tx_dat   <= 8'hA5;
                            hdr_next <= S_HDR1;
                        end else if (state == S_HDR1) begin
                            tx_dat   <= 8'h5A;
                            hdr_next <= S_HDR2;
                        end else begin
                            tx_dat   <= 8'(POST_WORDS);
                            hdr_next <= S_DUMP_RD;
                        end
                    end
                end

                S_WAIT_HDR: begin
                    if (wait_skip) begin
                        wait_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        state <= hdr_next;
                    end
                end
`endif

                // Address registered on entry; RAM samples it one edge later, data valid the edge after.
                S_DUMP_RD: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        rd_wait <= 1'b0;
                        word    <= ram_rdata;
                        state   <= S_DUMP_LO;
                    end
                end

                S_DUMP_LO: begin
                    if (!tx_busy) begin
                        tx_dat    <= word[7:0];
                        tx_start  <= 1'b1;
                        wait_skip <= 1'b1;
                        state     <= S_WAIT_LO;
                    end
                end

                S_DUMP_HI: begin
                    if (!tx_busy) begin
                        tx_dat    <= word[15:8];
                        tx_start  <= 1'b1;
                        wait_skip <= 1'b1;
                        state     <= S_WAIT_HI;
                    end
                end

                S_WAIT_LO: begin
                    if (wait_skip) begin
                        wait_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        state <= S_DUMP_HI;
                    end
                end

                S_WAIT_HI: begin
                    if (wait_skip) begin
                        wait_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        ram_raddr <= ram_raddr + AW'(1);
                        rd_cnt    <= rd_cnt + AW'(1);
                        if (&rd_cnt) begin
                            capturing <= 1'b1;
                            dumping   <= 1'b0;
                            state     <= S_REC;
                        end else begin
                            state <= S_DUMP_RD;
                        end
                    end
                end

                default: begin
                    state <= S_REC;
                end
            endcase
        end
    end

endmodule
